segment_transition: RTL and testbench

SEGMENT_TRANSITION -- requirements
Module: segment_transition

---
 rtl/segment_transition_pkg.sv | 27 ++
 rtl/segment_transition_rep_counter.sv | 29 ++
 rtl/segment_transition.sv | 129 ++++++++++++
 tb/tb_segment_transition.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_transition_pkg.sv
// Shared types and constants for the segment transition controller.
package segment_transition_pkg;

  localparam int NumSegment = 2;

  localparam logic [7:0] ExtModeCode = 8'hF0;

  typedef enum logic [7:0] {
    MODE_SYNC_IDX = 8'h00,
    MODE_SYS_TIME = 8'h01,
    MODE_GPIO     = 8'h02,
    MODE_EXT      = ExtModeCode
  } transition_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_WAIT_TIME,
    ST_WAIT_GPIO,
    ST_EXT_RUN
  } state_t;

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/segment_transition_rep_counter.sv
// Per-segment loop counter; flags exhaustion when the count reaches a finite repeat budget.
module rep_counter #(
  parameter int RepWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                inc,
  input  logic [RepWidth-1:0] rep,
  output logic                exhausted
);

  logic [RepWidth-1:0] count;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // An all-ones budget means play forever.
  assign exhausted = (count == rep) && (rep != '1);

endmodule

// File: rtl/segment_transition.sv
// Segment sequencer: arms a transition on UPDATE and switches segment on a loop, time, GPIO or repeat trigger.
module segment_transition #(
  parameter int NumSegment = segment_transition_pkg::NumSegment,
  parameter int NumGpio    = 4,
  parameter int RepWidth   = 16,
  localparam int SegW      = segment_transition_pkg::index_width(NumSegment),
  localparam int GpioW     = segment_transition_pkg::index_width(NumGpio)
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               UPDATE,
  input  logic [SegW-1:0]                    REQ_SEGMENT,
  input  logic [7:0]                         TRANSITION_MODE,
  input  logic [63:0]                        TRANSITION_VALUE,
  input  logic [NumSegment-1:0][RepWidth-1:0] REP,
  input  logic [63:0]                        SYS_TIME,
  input  logic                               LOOP_END,
  input  logic [NumGpio-1:0]                 GPIO_IN,
  output logic [SegW-1:0]                    SEGMENT,
  output logic                               STOP,
  output logic                               PENDING,
  output logic                               SWITCHED
);

  import segment_transition_pkg::*;

  state_t              state;
  state_t              upd_state;
  logic [SegW-1:0]     target;
  logic [SegW-1:0]     next_seg;
  logic [SegW-1:0]     switch_seg;
  logic [63:0]         time_val;
  logic [GpioW-1:0]    gpio_idx;
  logic [NumGpio-1:0]  gpio_q;
  logic                mode_ok;
  logic                upd_valid;
  logic                trig;
  logic                do_switch;
  logic                count_evt;
  logic                exhausted;
  logic                stop_set;

  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    mode_ok   = 1'b1;
    upd_state = ST_IDLE;
    case (TRANSITION_MODE)
      MODE_SYNC_IDX: upd_state = ST_WAIT_SYNC;
      MODE_SYS_TIME: upd_state = ST_WAIT_TIME;
      MODE_GPIO:     upd_state = ST_WAIT_GPIO;
      MODE_EXT:      upd_state = ST_EXT_RUN;
      default:       mode_ok   = 1'b0;
    endcase
  end

  assign upd_valid = UPDATE && mode_ok && (32'(REQ_SEGMENT) < 32'(NumSegment));
  assign next_seg  = (SEGMENT == SegW'(NumSegment - 1)) ? '0 : SEGMENT + 1'b1;

  always_comb begin
    trig       = 1'b0;
    switch_seg = target;
    case (state)
      ST_WAIT_SYNC: trig = LOOP_END;
      ST_WAIT_TIME: trig = (SYS_TIME >= time_val);
      ST_WAIT_GPIO: trig = GPIO_IN[gpio_idx] && !gpio_q[gpio_idx];
      ST_EXT_RUN: begin
        trig       = LOOP_END && exhausted;
        switch_seg = next_seg;
      end
      default: ;
    endcase
  end

  // A fresh request supersedes whatever the old one would have fired on this cycle.
  assign do_switch = trig && !upd_valid;
  assign count_evt = LOOP_END && !STOP && !do_switch;
  assign stop_set  = count_evt && exhausted && (state != ST_EXT_RUN);

  rep_counter #(
    .RepWidth (RepWidth)
  ) u_rep_counter (
    .clk       (CLK),
    .rst       (RST),
    .clear     (do_switch),
    .inc       (count_evt),
    .rep       (REP[SEGMENT]),
    .exhausted (exhausted)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      SEGMENT  <= '0;
      STOP     <= 1'b0;
      PENDING  <= 1'b0;
      SWITCHED <= 1'b0;
      target   <= '0;
      time_val <= '0;
      gpio_idx <= '0;
      gpio_q   <= '0;
    end else begin
      gpio_q   <= GPIO_IN;
      SWITCHED <= 1'b0;
      if (upd_valid) begin
        state    <= upd_state;
        target   <= REQ_SEGMENT;
        time_val <= TRANSITION_VALUE;
        gpio_idx <= TRANSITION_VALUE[GpioW-1:0];
        PENDING  <= (upd_state != ST_EXT_RUN);
        if (upd_state == ST_EXT_RUN) begin
          STOP <= 1'b0;
        end else if (stop_set) begin
          STOP <= 1'b1;
        end
      end else if (do_switch) begin
        SEGMENT  <= switch_seg;
        SWITCHED <= 1'b1;
        STOP     <= 1'b0;
        PENDING  <= 1'b0;
        if (state != ST_EXT_RUN) begin
          state <= ST_IDLE;
        end
      end else if (stop_set) begin
        STOP <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_segment_transition.sv
// Scoreboard bench for segment_transition: directed scenarios plus random traffic vs a behavioural model.
module tb_segment_transition;

  localparam int NSEG = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             update;
  logic [1:0]       req_segment;
  logic [7:0]       mode;
  logic [63:0]      value;
  logic [3:0][15:0] rep;
  logic [63:0]      sys_time;
  logic             loop_end;
  logic [3:0]       gpio;
  logic [1:0]       segment;
  logic             stop;
  logic             pending;
  logic             switched;

  segment_transition #(
    .NumSegment (NSEG),
    .NumGpio    (4),
    .RepWidth   (16)
  ) dut (
    .CLK              (clk),
    .RST              (rst),
    .UPDATE           (update),
    .REQ_SEGMENT      (req_segment),
    .TRANSITION_MODE  (mode),
    .TRANSITION_VALUE (value),
    .REP              (rep),
    .SYS_TIME         (sys_time),
    .LOOP_END         (loop_end),
    .GPIO_IN          (gpio),
    .SEGMENT          (segment),
    .STOP             (stop),
    .PENDING          (pending),
    .SWITCHED         (switched)
  );

  always #5 clk = ~clk;

  typedef struct {
    int seg;
    bit stop;
    bit pend;
    bit sw;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what is armed, what the playing segment is, and how many loops it has played.
  typedef enum {ARM_NONE, ARM_LOOP, ARM_TIME, ARM_GPIO} arm_e;
  arm_e        m_arm    = ARM_NONE;
  bit          m_ext    = 0;
  int          m_seg    = 0;
  int          m_target = 0;
  bit          m_stop   = 0;
  int          m_cnt    = 0;
  logic [63:0] m_time   = '0;
  int          m_gidx   = 0;
  logic [3:0]  m_gprev  = '0;

  task automatic model_step(output exp_t e);
    bit valid, fire, counted, hit, old_ext, exh;
    int nseg;
    e.sw = 0;
    if (rst) begin
      m_arm = ARM_NONE; m_ext = 0; m_seg = 0; m_stop = 0; m_cnt = 0; m_gprev = '0;
    end else begin
      valid = update && (mode == 8'h00 || mode == 8'h01 || mode == 8'h02 || mode == 8'hF0)
              && (int'(req_segment) < NSEG);
      exh   = (m_cnt == int'(rep[m_seg])) && (rep[m_seg] != 16'hFFFF);
      fire  = 0;
      nseg  = m_target;
      if (!valid) begin
        case (m_arm)
          ARM_LOOP: fire = loop_end;
          ARM_TIME: fire = (sys_time >= m_time);
          ARM_GPIO: fire = gpio[m_gidx] && !m_gprev[m_gidx];
          default:  fire = 0;
        endcase
        if (m_ext && loop_end && exh) begin
          fire = 1;
          nseg = (m_seg + 1) % NSEG;
        end
      end
      counted = loop_end && !m_stop && !fire;
      hit     = counted && exh;
      old_ext = m_ext;
      if (valid) begin
        m_target = int'(req_segment);
        m_time   = value;
        m_gidx   = int'(value[1:0]);
        m_ext    = (mode == 8'hF0);
        m_arm    = (mode == 8'h00) ? ARM_LOOP : (mode == 8'h01) ? ARM_TIME :
                   (mode == 8'h02) ? ARM_GPIO : ARM_NONE;
        if (m_ext) m_stop = 0;
        else if (hit && !old_ext) m_stop = 1;
      end else if (fire) begin
        m_seg = nseg; e.sw = 1; m_stop = 0; m_arm = ARM_NONE; m_cnt = 0;
      end else if (hit && !old_ext) begin
        m_stop = 1;
      end
      if (counted) m_cnt = (m_cnt + 1) % 65536;
      m_gprev = gpio;
    end
    e.seg  = m_seg;
    e.stop = m_stop;
    e.pend = (m_arm != ARM_NONE);
  endtask

  // Inputs are applied at the falling edge; the matching expectation is queued for the next rising edge.
  task automatic tick();
    exp_t e;
    model_step(e);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("segment@%0d", cyc), 64'(segment), 64'(e.seg));
        check($sformatf("stop@%0d", cyc), 64'(stop), 64'(e.stop));
        check($sformatf("pending@%0d", cyc), 64'(pending), 64'(e.pend));
        check($sformatf("switched@%0d", cyc), 64'(switched), 64'(e.sw));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  task automatic pulse_loop();
    loop_end = 1'b1;
    tick();
    loop_end = 1'b0;
    tick();
  endtask

  task automatic request(input logic [7:0] m, input logic [1:0] tgt, input logic [63:0] v);
    update = 1'b1; mode = m; req_segment = tgt; value = v;
    tick();
    update = 1'b0;
  endtask

  initial begin : stimulus
    rst = 1'b1; update = 1'b0; req_segment = '0; mode = '0; value = '0;
    sys_time = 64'd0; loop_end = 1'b0; gpio = '0;
    for (int s = 0; s < 4; s++) rep[s] = 16'hFFFF;
    tick();
    tick();
    rst = 1'b0;
    check("reset_segment", 64'(segment), 64'd0);
    check("reset_stop", 64'(stop), 64'd0);
    check("reset_pending", 64'(pending), 64'd0);
    check("reset_switched", 64'(switched), 64'd0);

    // Loop-synchronised switch; the LOOP_END alongside UPDATE must not fire it.
    loop_end = 1'b1;
    request(8'h00, 2'd1, 64'd0);
    loop_end = 1'b0;
    check("sync_armed_pending", 64'(pending), 64'd1);
    check("sync_armed_segment", 64'(segment), 64'd0);
    repeat (4) tick();
    loop_end = 1'b1;
    tick();
    loop_end = 1'b0;
    check("sync_segment", 64'(segment), 64'd1);
    check("sync_switched", 64'(switched), 64'd1);
    check("sync_pending_low", 64'(pending), 64'd0);
    tick();
    check("sync_switched_one_cycle", 64'(switched), 64'd0);

    // Time-triggered switch at exactly SYS_TIME == value.
    sys_time = 64'd990;
    request(8'h01, 2'd2, 64'd1000);
    while (sys_time < 64'd1000) begin
      sys_time = sys_time + 64'd1;
      tick();
      if (sys_time < 64'd1000) check("time_early_hold", 64'(segment), 64'd1);
    end
    check("time_match_segment", 64'(segment), 64'd2);
    check("time_match_switched", 64'(switched), 64'd1);

    // A value already in the past fires on the first armed cycle.
    sys_time = 64'd990;
    request(8'h01, 2'd3, 64'd500);
    check("time_past_armed", 64'(segment), 64'd2);
    tick();
    check("time_past_segment", 64'(segment), 64'd3);

    // GPIO line already high at UPDATE needs a fresh low-to-high edge.
    gpio = 4'b0100;
    tick();
    request(8'h02, 2'd0, 64'd2);
    repeat (3) tick();
    check("gpio_high_no_switch", 64'(segment), 64'd3);
    check("gpio_still_pending", 64'(pending), 64'd1);
    gpio = 4'b0000;
    tick();
    check("gpio_low_no_switch", 64'(segment), 64'd3);
    gpio = 4'b0100;
    tick();
    check("gpio_edge_segment", 64'(segment), 64'd0);
    check("gpio_edge_switched", 64'(switched), 64'd1);

    // Finite repeat budget: REP=2 stops on the third loop.
    rep[0] = 16'd2;
    pulse_loop();
    check("rep2_loop1", 64'(stop), 64'd0);
    pulse_loop();
    check("rep2_loop2", 64'(stop), 64'd0);
    pulse_loop();
    check("rep2_loop3_stop", 64'(stop), 64'd1);
    pulse_loop();
    check("rep2_stop_held", 64'(stop), 64'd1);

    // Infinite budget never stops; the switch clears STOP.
    rep[0] = 16'hFFFF;
    request(8'h00, 2'd0, 64'd0);
    loop_end = 1'b1;
    tick();
    loop_end = 1'b0;
    check("stop_cleared_by_switch", 64'(stop), 64'd0);
    repeat (100) pulse_loop();
    check("rep_inf_no_stop", 64'(stop), 64'd0);

    // Counter fresh from a switch, then EXT auto-advance with REP=0 everywhere.
    request(8'h00, 2'd0, 64'd0);
    loop_end = 1'b1;
    tick();
    loop_end = 1'b0;
    for (int s = 0; s < 4; s++) rep[s] = 16'd0;
    request(8'hF0, 2'd0, 64'd0);
    check("ext_not_pending", 64'(pending), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      loop_end = 1'b1;
      tick();
      loop_end = 1'b0;
      check($sformatf("ext_seq_%0d", k), 64'(segment), 64'(k % 4));
      check($sformatf("ext_stop_%0d", k), 64'(stop), 64'd0);
      tick();
    end

    // Reset while waiting on time discards the request.
    for (int s = 0; s < 4; s++) rep[s] = 16'hFFFF;
    request(8'h01, 2'd2, sys_time + 64'd20);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wait_segment", 64'(segment), 64'd0);
    check("rst_wait_pending", 64'(pending), 64'd0);
    repeat (30) begin
      sys_time = sys_time + 64'd1;
      tick();
    end
    check("rst_no_late_switch", 64'(segment), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 499) == 0);
      update = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0:       mode = 8'h00;
        1:       mode = 8'h01;
        2:       mode = 8'h02;
        3:       mode = 8'hF0;
        default: mode = 8'($urandom_range(3, 239));
      endcase
      req_segment = 2'($urandom_range(0, 3));
      value = {$urandom, $urandom};
      if (mode == 8'h01) value = sys_time + 64'($urandom_range(0, 40)) - 64'd10;
      loop_end = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) gpio = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        for (int s = 0; s < 4; s++)
          rep[s] = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
      end
      sys_time = sys_time + 64'($urandom_range(0, 2));
      tick();
    end

    rst = 1'b0; update = 1'b0; loop_end = 1'b0;
    tick();
    tick();
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
